// File: rtl/cheshire_rtc_gen_pkg.sv
// rtl/cheshire_rtc_gen_pkg.sv - shared constants for the RTC generator
package cheshire_rtc_gen_pkg;

   localparam int unsigned RtcDivIntDefault  = 25;
   localparam int unsigned RtcDivFracDefault = 0;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/cheshire_rtc_gen.sv
// rtl/cheshire_rtc_gen.sv - integer+fractional RTC divider with divisor update handshake
// Half-periods are eff cycles, stretched by one whenever the phase accumulator carries.
module cheshire_rtc_gen
   import cheshire_rtc_gen_pkg::*;
#(
   parameter int unsigned CntWidth       = 16,
   parameter int unsigned FracWidth      = 8,
   parameter int unsigned DefaultDivInt  = RtcDivIntDefault,
   parameter int unsigned DefaultDivFrac = RtcDivFracDefault
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic [CntWidth-1:0]  div_int_i,
   input  logic [FracWidth-1:0] div_frac_i,
   input  logic                 div_valid_i,
   output logic                 div_ready_o,
   output logic                 rtc_o,
   output logic                 tick_o
);

   logic [CntWidth-1:0]  r_cnt;
   logic [CntWidth-1:0]  r_int;
   logic [CntWidth-1:0]  r_int_sh;
   logic [FracWidth-1:0] r_acc;
   logic [FracWidth-1:0] r_frac;
   logic [FracWidth-1:0] r_frac_sh;
   logic                 r_ext;
   logic                 r_pend;
   logic                 r_rtc;
   logic                 r_tick;
   logic [0:0]           r_state;

   logic [CntWidth-1:0]  w_eff;
   logic [CntWidth:0]    w_lim_m1;
   logic [FracWidth:0]   w_sum;
   logic                 w_toggle;
   logic                 w_accept;

   // One extra bit so eff + ext cannot wrap at the maximum divisor.
   assign w_eff    = (r_int == '0) ? CntWidth'(1) : r_int;
   assign w_lim_m1 = {1'b0, w_eff} + {{CntWidth{1'b0}}, r_ext} - (CntWidth+1)'(1);
   assign w_toggle = (r_state == ST_RUN) && ({1'b0, r_cnt} == w_lim_m1);
   assign w_sum    = {1'b0, r_acc} + {1'b0, r_frac};
   assign w_accept = div_valid_i && !r_pend;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_ext     <= 1'b0;
         r_int     <= CntWidth'(DefaultDivInt);
         r_frac    <= FracWidth'(DefaultDivFrac);
         r_int_sh  <= CntWidth'(DefaultDivInt);
         r_frac_sh <= FracWidth'(DefaultDivFrac);
         r_pend    <= 1'b0;
         r_state   <= ST_IDLE;
         r_rtc     <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         if (r_state == ST_IDLE) begin
            r_rtc  <= 1'b0;
            r_tick <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_ext  <= 1'b0;
            if (r_pend) begin
               r_int  <= r_int_sh;
               r_frac <= r_frac_sh;
               r_pend <= 1'b0;
            end
            if (en_i) r_state <= ST_RUN;
         end else if (!en_i) begin
            r_state <= ST_IDLE;
            r_rtc   <= 1'b0;
            r_tick  <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ext   <= 1'b0;
         end else if (w_toggle) begin
            r_rtc  <= ~r_rtc;
            r_tick <= ~r_rtc;
            r_cnt  <= '0;
            // A pending divisor starts a fresh phase, so the old fraction is dropped.
            if (r_pend) begin
               r_int  <= r_int_sh;
               r_frac <= r_frac_sh;
               r_acc  <= '0;
               r_ext  <= 1'b0;
               r_pend <= 1'b0;
            end else begin
               r_acc <= w_sum[FracWidth-1:0];
               r_ext <= w_sum[FracWidth];
            end
         end else begin
            r_cnt  <= r_cnt + CntWidth'(1);
            r_tick <= 1'b0;
         end

         if (w_accept) begin
            r_int_sh  <= div_int_i;
            r_frac_sh <= div_frac_i;
            r_pend    <= 1'b1;
         end
      end
   end

   assign div_ready_o = !r_pend;
   assign rtc_o       = r_rtc;
   assign tick_o      = r_tick;

endmodule

// File: tb/tb_cheshire_rtc_gen.sv
// tb/tb_cheshire_rtc_gen.sv - self-checking bench for cheshire_rtc_gen
module tb_cheshire_rtc_gen;

   localparam int CW = 16;
   localparam int FW = 8;
   localparam longint SCALE = 256;

   logic          clk_i       = 1'b0;
   logic          rst_ni      = 1'b0;
   logic          en_i        = 1'b0;
   logic [CW-1:0] div_int_i   = '0;
   logic [FW-1:0] div_frac_i  = '0;
   logic          div_valid_i = 1'b0;
   logic          div_ready_o;
   logic          rtc_o;
   logic          tick_o;

   always #5 clk_i = ~clk_i;

   cheshire_rtc_gen #(
      .CntWidth(CW), .FracWidth(FW), .DefaultDivInt(25), .DefaultDivFrac(0)
   ) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i),
      .div_int_i(div_int_i), .div_frac_i(div_frac_i), .div_valid_i(div_valid_i),
      .div_ready_o(div_ready_o), .rtc_o(rtc_o), .tick_o(tick_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: half-period n of a divisor epoch lasts eff plus the number of
   // whole units that n*frac/2^F gained over (n-1)*frac/2^F.
   bit     m_run, m_lvl, m_tick, m_pend, m_acc_now;
   longint m_int, m_frac, m_sh_int, m_sh_frac, m_n, m_left;

   function automatic longint hp_len(input longint n);
      longint eff;
      eff = (m_int == 0) ? 1 : m_int;
      if (n == 0) return eff;
      return eff + (n * m_frac) / SCALE - ((n - 1) * m_frac) / SCALE;
   endfunction

   task automatic model_reset();
      m_run = 0; m_lvl = 0; m_tick = 0; m_pend = 0; m_acc_now = 0;
      m_int = 25; m_frac = 0; m_sh_int = 25; m_sh_frac = 0; m_n = 0; m_left = 0;
   endtask

   task automatic model_edge();
      bit acc;
      acc = div_valid_i && !m_pend;
      if (!m_run) begin
         m_lvl = 0; m_tick = 0;
         if (m_pend) begin m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0; end
         if (en_i) begin m_run = 1; m_n = 0; m_left = hp_len(0); end
      end else if (!en_i) begin
         m_run = 0; m_lvl = 0; m_tick = 0;
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_tick = !m_lvl;
            m_lvl  = !m_lvl;
            m_n++;
            if (m_pend) begin m_int = m_sh_int; m_frac = m_sh_frac; m_pend = 0; m_n = 0; end
            m_left = hp_len(m_n);
         end else begin
            m_tick = 0;
         end
      end
      if (acc) begin m_pend = 1; m_sh_int = div_int_i; m_sh_frac = div_frac_i; end
      m_acc_now = acc;
   endtask

   task automatic step();
      @(posedge clk_i);
      model_edge();
      #1;
      check_eq("rtc", rtc_o, m_lvl);
      check_eq("tick", tick_o, m_tick);
      check_eq("ready", div_ready_o, !m_pend);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin step(); n++; end while (!tick_o && n < 400);
      if (!tick_o) check_eq("tick_timeout", n, -1);
   endtask

   task automatic wait_level(input bit lvl, output int n);
      n = 0;
      do begin step(); n++; end while (rtc_o != lvl && n < 400);
      if (rtc_o != lvl) check_eq("level_timeout", n, -1);
   endtask

   task automatic request(input int di, input int df);
      int n;
      div_int_i = CW'(di); div_frac_i = FW'(df); div_valid_i = 1'b1;
      n = 0;
      do begin step(); n++; end while (!m_acc_now && n < 400);
      div_valid_i = 1'b0;
      if (!m_acc_now) check_eq("accept_timeout", n, -1);
      n = 0;
      while (!div_ready_o && n < 400) begin step(); n++; end
      if (!div_ready_o) check_eq("apply_timeout", n, -1);
   endtask

   initial begin
      int n;
      model_reset();
      repeat (2) @(negedge clk_i);
      check_eq("rst_rtc", rtc_o, 0);
      check_eq("rst_tick", tick_o, 0);
      check_eq("rst_ready", div_ready_o, 1);
      rst_ni = 1'b1;

      en_i = 1'b1;
      n = 0;
      do begin step(); n++; end while (!rtc_o && n < 200);
      check_eq("first_rise", n, 26);
      wait_tick(n);
      check_eq("default_period", n, 50);

      repeat (5) step();
      div_int_i = 10; div_frac_i = 0; div_valid_i = 1'b1;
      step();
      check_eq("upd_ready_low", div_ready_o, 0);
      div_int_i = 7;
      wait_level(0, n);
      check_eq("upd_old_half", n, 19);
      check_eq("upd_ready_back", div_ready_o, 1);
      step();
      check_eq("second_accept", div_ready_o, 0);
      div_valid_i = 1'b0;
      wait_level(1, n);
      check_eq("upd_half10", n + 1, 10);
      wait_level(0, n);
      check_eq("upd_half7", n, 7);

      request(3, 128);
      wait_tick(n); wait_tick(n);
      wait_tick(n);
      check_eq("frac_period_a", n, 7);
      wait_tick(n);
      check_eq("frac_period_b", n, 7);

      request(0, 0);
      wait_tick(n);
      wait_tick(n);
      check_eq("div0_period", n, 2);
      repeat (6) step();

      request(4, 0);
      wait_level(1, n);
      en_i = 1'b0;
      step();
      check_eq("endrop_rtc", rtc_o, 0);
      check_eq("endrop_tick", tick_o, 0);
      repeat (3) step();
      en_i = 1'b1;
      wait_level(1, n);
      check_eq("reenable_rise", n, 5);

      for (int i = 0; i < 1500; i++) begin
         en_i = ($urandom_range(0, 19) != 0);
         if (!div_valid_i && $urandom_range(0, 15) == 0) begin
            div_valid_i = 1'b1;
            div_int_i   = CW'($urandom_range(0, 6));
            div_frac_i  = FW'($urandom_range(0, 255));
         end
         step();
         if (m_acc_now) div_valid_i = 1'b0;
      end

      en_i = 1'b1;
      div_valid_i = 1'b0;
      repeat (2) step();
      n = 0;
      while (m_pend && n < 400) begin step(); n++; end
      div_int_i = 9; div_frac_i = 0; div_valid_i = 1'b1;
      step();
      div_valid_i = 1'b0;
      check_eq("pend_before_rst", div_ready_o, 0);
      #3;
      rst_ni = 1'b0;
      #1;
      check_eq("arst_rtc", rtc_o, 0);
      check_eq("arst_tick", tick_o, 0);
      check_eq("arst_ready", div_ready_o, 1);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      n = 0;
      do begin step(); n++; end while (!rtc_o && n < 200);
      check_eq("arst_first_rise", n, 26);
      wait_tick(n);
      check_eq("arst_period", n, 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cheshire_rtc_gen.md
# cheshire_rtc_gen

Parametrised real-time-clock generator for Cheshire FPGA and ASIC tops. It replaces the fixed divide-by-50 RTC counter with a runtime-programmable integer-plus-fractional divider. It produces a 50%-nominal-duty `rtc_o` for `cheshire_soc.rtc_i` and a one-cycle `tick_o` pulse. It sits in the top level, clocked by `soc_clk` and reset by the `rstgen` output.

## Interface
- `CntWidth`, default 16: width of the integer half-period divisor and of the cycle counter.
- `FracWidth`, default 8: width of the fractional divisor and of the phase accumulator.
- `DefaultDivInt`, default 25: integer half-period loaded at reset (50 MHz to 1 MHz).
- `DefaultDivFrac`, default 0: fractional half-period loaded at reset.
- `clk_i`, in, 1: system clock.
- `rst_ni`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `en_i`, in, 1: run enable.
- `div_int_i`, in, `CntWidth`: new integer half-period, in cycles.
- `div_frac_i`, in, `FracWidth`: new fractional half-period, in units of 2^-FracWidth cycles.
- `div_valid_i`, in, 1: divisor update request.
- `div_ready_o`, out, 1: divisor update can be accepted.
- `rtc_o`, out, 1: generated RTC clock, register-driven.
- `tick_o`, out, 1: one-cycle pulse coincident with the first high cycle of `rtc_o`.

## Operation
- Registers:
  - `cnt_q` (`CntWidth`)
  - `acc_q` (`FracWidth`)
  - `ext_q` (1)
  - `int_q` and `frac_q` (active divisor)
  - `int_sh_q` and `frac_sh_q` (shadow divisor)
  - `pend_q`
  - `state_q` (IDLE or RUN)
  - `rtc_q`
  - `tick_q`
- Reset values:
  - `rtc_o`=0, `tick_o`=0, `div_ready_o`=1
  - `cnt_q`=0, `acc_q`=0, `ext_q`=0, `pend_q`=0
  - `int_q`=`DefaultDivInt`, `frac_q`=`DefaultDivFrac`
  - `state_q`=IDLE
- Effective integer divisor `eff` = max(`int_q`, 1). A value of 0 is treated as 1.
- Half-period limit `lim` = `eff` + `ext_q`. This is computed `CntWidth`+1 bits wide, so there is no overflow at `int_q` = 2^CntWidth-1.
- IDLE:
  - `rtc_q`, `cnt_q`, `acc_q` and `ext_q` are held at 0.
  - If `pend_q` is set, the shadow divisor is copied to the active divisor and `pend_q` is cleared on the next edge.
  - `en_i`=1 moves to RUN with `cnt_q`=0.
- RUN, each cycle:
  - If `cnt_q` == `lim`-1 (a toggle edge):
    - `rtc_q` is inverted and `cnt_q` is set to 0.
    - {carry, `acc_q`} = `acc_q` + `frac_q`; `ext_q` = carry.
    - `tick_q` = 1 if `rtc_q` was 0.
    - If `pend_q` is set: the shadow divisor is copied to the active divisor, `acc_q` and `ext_q` are cleared, and `pend_q` is cleared.
  - Otherwise `cnt_q` is incremented and `tick_q` = 0.
- RUN with `en_i`=0 moves to IDLE on the next edge: `rtc_o` goes to 0, `tick_o` goes to 0, and the counters are cleared.
- Update handshake:
  - `div_ready_o` = !`pend_q`.
  - `div_valid_i` && `div_ready_o` on an edge writes the shadow registers and sets `pend_q`.
  - `div_valid_i` may be held while ready is low. The request waits and no data is lost.
  - A request accepted on the same edge as a toggle is not applied on that edge. It is applied at the following toggle, or on the next edge if the block is in IDLE.
- Average half-period = `eff` + `frac_q`/2^FracWidth cycles.

## Timing
- All outputs are registered. There is no combinational path from inputs to `rtc_o` or `tick_o`. `div_ready_o` comes from `pend_q` only.
- First rising edge of `rtc_o`: `eff` cycles after the edge on which the block enters RUN.
- `tick_o` is high for exactly one cycle per `rtc_o` period, in the first high cycle.
- Update latency: `div_ready_o` drops on the cycle after acceptance. It returns high on the cycle after the applying toggle edge.
- The half-period in progress at acceptance always completes with the old divisor. There are no runt pulses.
- Asynchronous reset mid-operation forces every register to its reset value immediately. Any pending update is discarded.

## Structure
- Add `RtcDivIntDefault` (25) and `RtcDivFracDefault` (0) to `cheshire_pkg`, next to `RtcFreq`. Tops pass them as parameters.
- No new typedefs are needed.
- The block is a single flat module. No sub-module is required; the accumulator is too small to split out.
- The top instantiates it with `clk_i`=`soc_clk`, `rst_ni`=`rst_n`, `en_i`=1 and `div_valid_i`=0. A regbus wrapper may drive the handshake later.

## Test plan
- Defaults with `en_i`=1 from reset: first rise 25 cycles after RUN entry, then a 50-cycle period (25 high, 25 low), and one `tick_o` per 50 cycles.
- `div_int`=3, `div_frac`=128 (`FracWidth`=8): half-periods are 3,3,4,3,4,… and every 14 cycles contain exactly 2 `tick_o` pulses after the first period.
- Update to 10/0 accepted mid half-period: ready low next cycle, current half-period finishes at 25, all following half-periods are 10, ready high the cycle after that toggle. A second valid held during the pend is accepted only then.
- `div_int`=0, `frac`=0: `rtc_o` toggles every cycle and `tick_o` is high every second cycle.
- `en_i` dropped while `rtc_o`=1: next cycle `rtc_o`=0 and `tick_o`=0. Re-enabling gives a first rise after a full `eff` cycles with `acc_q`=0.
- `rst_ni` asserted asynchronously mid-cycle with an update pending: `rtc_o`=0, `tick_o`=0 and `div_ready_o`=1 immediately. After release, a 50-cycle period is measured again.
